// File: rtl/ram_pkg.sv
// Shared definitions for the byte-write SDP RAM: address sizing, collision modes, state encoding.
package ram_pkg;

   // Address bits needed for a given depth; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

   localparam string RAM_READ_FIRST  = "READ_FIRST";
   localparam string RAM_WRITE_FIRST = "WRITE_FIRST";

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/sdp_rd_pipe.sv
// Read pipeline: C_STAGES data registers with a freely shifting valid chain.
// Data in a stage only advances behind a valid, so dataout holds between reads.
module sdp_rd_pipe #(
   parameter int C_WIDTH  = 64,
   parameter int C_STAGES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [C_WIDTH-1:0] i_data,
   output logic [C_WIDTH-1:0] o_data,
   output logic               o_valid
);

   logic [C_STAGES-1:0]              r_vld;
   logic [C_STAGES-1:0][C_WIDTH-1:0] r_data;

   // Shift valids every cycle; load each data stage only when the stage before it holds a valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_data <= '0;
      end else begin
         r_vld[0] <= i_load;
         if (i_load) r_data[0] <= i_data;
         for (int k = 1; k < C_STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) r_data[k] <= r_data[k-1];
         end
      end
   end

   assign o_data  = r_data[C_STAGES-1];
   assign o_valid = r_vld[C_STAGES-1];

endmodule

// File: rtl/xilinx_sdp_bytewr_ram.sv
// Simple dual-port RAM with byte-lane writes, 1..4 stage registered read,
// selectable same-address collision behaviour and an optional zeroing sweep after reset.
module xilinx_sdp_bytewr_ram
   import ram_pkg::*;
#(
   parameter int    C_RAM_WIDTH      = 64,
   parameter int    C_RAM_DEPTH      = 512,
   parameter int    C_BYTE_WIDTH     = 8,
   parameter int    C_RD_LATENCY     = 1,
   parameter string C_COLLISION      = "READ_FIRST",
   parameter int    C_CLEAR_ON_RESET = 1,
   localparam int   NB               = C_RAM_WIDTH / C_BYTE_WIDTH,
   localparam int   AW               = clog2(C_RAM_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wren,
   input  logic [NB-1:0]          wrByteEn,
   input  logic [AW-1:0]          wrAddr,
   input  logic [C_RAM_WIDTH-1:0] datain,
   input  logic                   rden,
   input  logic [AW-1:0]          rdAddr,
   output logic [C_RAM_WIDTH-1:0] dataout,
   output logic                   dataout_valid,
   output logic                   init_done
);

   localparam logic [AW:0]   LP_DEPTH       = (AW+1)'(C_RAM_DEPTH);
   localparam logic [AW-1:0] LP_LAST        = AW'(C_RAM_DEPTH - 1);
   localparam bit            LP_WRITE_FIRST = (C_COLLISION == RAM_WRITE_FIRST);
   localparam logic [0:0]    LP_RST_STATE   = (C_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   if ((C_RAM_WIDTH % C_BYTE_WIDTH) != 0) begin : g_bad_width
      $error("C_RAM_WIDTH must be a multiple of C_BYTE_WIDTH");
   end
   if ((C_RD_LATENCY < 1) || (C_RD_LATENCY > 4)) begin : g_bad_latency
      $error("C_RD_LATENCY must be in 1..4");
   end
   if (!((C_COLLISION == RAM_READ_FIRST) || (C_COLLISION == RAM_WRITE_FIRST))) begin : g_bad_collision
      $error("C_COLLISION must be READ_FIRST or WRITE_FIRST");
   end

   logic [C_RAM_WIDTH-1:0] r_mem [0:C_RAM_DEPTH-1];
   logic [0:0]             r_state;
   logic [AW-1:0]          r_clr_cnt;
   logic                   r_init_done;

   logic                   w_user_wr;
   logic                   w_user_rd;
   logic                   w_rd_in_range;
   logic                   w_collide;
   logic                   w_wr_en;
   logic [NB-1:0]          w_wr_be;
   logic [AW-1:0]          w_wr_addr;
   logic [C_RAM_WIDTH-1:0] w_wr_data;
   logic [C_RAM_WIDTH-1:0] w_rd_word;

   // User traffic is only honoured once init_done is registered high and never during reset.
   assign w_user_wr     = wren & r_init_done & rst_n & ({1'b0, wrAddr} < LP_DEPTH);
   assign w_user_rd     = rden & r_init_done & rst_n;
   assign w_rd_in_range = ({1'b0, rdAddr} < LP_DEPTH);
   assign w_collide     = LP_WRITE_FIRST && w_user_wr && (wrAddr == rdAddr);

   // Sweep counter and CLEAR->READY sequencing; init_done trails READY by one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= LP_RST_STATE;
         r_clr_cnt   <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_init_done <= (r_state == ST_READY);
         if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
            if (r_clr_cnt == LP_LAST) r_state <= ST_READY;
         end
      end
   end

   // Single write port shared by the clear sweep and user writes.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_be   = wrByteEn;
      w_wr_addr = wrAddr;
      w_wr_data = datain;
      if (r_state == ST_CLEAR) begin
         w_wr_en   = rst_n;
         w_wr_be   = '1;
         w_wr_addr = r_clr_cnt;
         w_wr_data = '0;
      end else begin
         w_wr_en   = w_user_wr;
      end
   end

   // Byte-lane write into the array; contents deliberately have no reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (w_wr_be[b])
               r_mem[w_wr_addr][b*C_BYTE_WIDTH +: C_BYTE_WIDTH] <= w_wr_data[b*C_BYTE_WIDTH +: C_BYTE_WIDTH];
         end
      end
   end

   // Read word: zero beyond depth; in WRITE_FIRST a same-address write merges its enabled lanes.
   always_comb begin
      w_rd_word = w_rd_in_range ? r_mem[rdAddr] : '0;
      if (w_collide) begin
         for (int b = 0; b < NB; b++) begin
            if (wrByteEn[b])
               w_rd_word[b*C_BYTE_WIDTH +: C_BYTE_WIDTH] = datain[b*C_BYTE_WIDTH +: C_BYTE_WIDTH];
         end
      end
   end

   sdp_rd_pipe #(
      .C_WIDTH  (C_RAM_WIDTH),
      .C_STAGES (C_RD_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_user_rd),
      .i_data  (w_rd_word),
      .o_data  (dataout),
      .o_valid (dataout_valid)
   );

   assign init_done = r_init_done;

endmodule

// File: tb/tb_xilinx_sdp_bytewr_ram.sv
// Directed bench: three RAM configurations on one clock, one task per scenario.
//   u_ram0: depth 512, latency 1, READ_FIRST,  clear on reset
//   u_ram1: depth 512, latency 3, WRITE_FIRST, clear on reset
//   u_ram2: depth 300, latency 4, READ_FIRST,  no clear
module tb_xilinx_sdp_bytewr_ram;

   localparam int W  = 64;
   localparam int AW = 9;
   localparam int NB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nchk  = 0;
   int nfail = 0;

   logic          rst_n [3];
   logic          wren  [3];
   logic [NB-1:0] be    [3];
   logic [AW-1:0] wa    [3];
   logic [W-1:0]  di    [3];
   logic          rden  [3];
   logic [AW-1:0] ra    [3];
   logic [W-1:0]  dout  [3];
   logic          dv    [3];
   logic          id    [3];

   xilinx_sdp_bytewr_ram #(.C_RAM_DEPTH(512), .C_RD_LATENCY(1), .C_COLLISION("READ_FIRST"),
                           .C_CLEAR_ON_RESET(1)) u_ram0 (
      .clk(clk), .rst_n(rst_n[0]), .wren(wren[0]), .wrByteEn(be[0]), .wrAddr(wa[0]),
      .datain(di[0]), .rden(rden[0]), .rdAddr(ra[0]), .dataout(dout[0]),
      .dataout_valid(dv[0]), .init_done(id[0]));

   xilinx_sdp_bytewr_ram #(.C_RAM_DEPTH(512), .C_RD_LATENCY(3), .C_COLLISION("WRITE_FIRST"),
                           .C_CLEAR_ON_RESET(1)) u_ram1 (
      .clk(clk), .rst_n(rst_n[1]), .wren(wren[1]), .wrByteEn(be[1]), .wrAddr(wa[1]),
      .datain(di[1]), .rden(rden[1]), .rdAddr(ra[1]), .dataout(dout[1]),
      .dataout_valid(dv[1]), .init_done(id[1]));

   xilinx_sdp_bytewr_ram #(.C_RAM_DEPTH(300), .C_RD_LATENCY(4), .C_COLLISION("READ_FIRST"),
                           .C_CLEAR_ON_RESET(0)) u_ram2 (
      .clk(clk), .rst_n(rst_n[2]), .wren(wren[2]), .wrByteEn(be[2]), .wrAddr(wa[2]),
      .datain(di[2]), .rden(rden[2]), .rdAddr(ra[2]), .dataout(dout[2]),
      .dataout_valid(dv[2]), .init_done(id[2]));

   function automatic logic [W-1:0] wordv(input int a);
      return 64'h0101_0101_0101_0101 * 64'(a + 1);
   endfunction

   // Called at a negedge; the write is sampled on the following posedge.
   task automatic do_write(input int k, input logic [AW-1:0] a, input logic [W-1:0] d,
                           input logic [NB-1:0] b);
      wren[k] = 1'b1; wa[k] = a; di[k] = d; be[k] = b;
      @(negedge clk);
      wren[k] = 1'b0; be[k] = '0;
   endtask

   // Issues one read and reports the first valid's data and its latency in cycles (-1 if none).
   task automatic do_read(input int k, input logic [AW-1:0] a, output logic [W-1:0] d,
                          output int lat);
      rden[k] = 1'b1; ra[k] = a; lat = -1; d = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) rden[k] = 1'b0;
         if (dv[k] === 1'b1 && lat < 0) begin lat = i; d = dout[k]; end
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; wren[k] = 1'b0; rden[k] = 1'b0; be[k] = '0;
         wa[k] = '0; ra[k] = '0; di[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         nchk++; if (dout[k] !== '0) begin nfail++; $display("FAIL reset_dout[%0d] got %h exp 0", k, dout[k]); end
         nchk++; if (dv[k] !== 1'b0) begin nfail++; $display("FAIL reset_valid[%0d] got %b exp 0", k, dv[k]); end
         nchk++; if (id[k] !== 1'b0) begin nfail++; $display("FAIL reset_init_done[%0d] got %b exp 0", k, id[k]); end
      end
   endtask

   task automatic test_clear_sweep();
      int rise0 = -1;
      int rise1 = -1;
      bit saw_dv = 1'b0;
      int addrs [3] = '{0, 255, 511};
      logic [W-1:0] d;
      int lat;
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
      for (int i = 1; i <= 520; i++) begin
         @(negedge clk);
         if (i == 1) begin
            nchk++; if (id[2] !== 1'b1) begin nfail++; $display("FAIL noclear_init_done got %b exp 1", id[2]); end
         end
         if (id[0] === 1'b1 && rise0 < 0) rise0 = i;
         if (id[1] === 1'b1 && rise1 < 0) rise1 = i;
         if (dv[0] === 1'b1) saw_dv = 1'b1;
         rden[0] = (i >= 10 && i < 20);
         ra[0]   = 9'd3;
      end
      rden[0] = 1'b0;
      nchk++; if (rise0 != 513) begin nfail++; $display("FAIL clear_rise0 got %0d exp 513", rise0); end
      nchk++; if (rise1 != 513) begin nfail++; $display("FAIL clear_rise1 got %0d exp 513", rise1); end
      nchk++; if (saw_dv) begin nfail++; $display("FAIL clear_rden_valid got 1 exp 0"); end
      for (int j = 0; j < 3; j++) begin
         do_read(0, AW'(addrs[j]), d, lat);
         nchk++; if (d !== '0) begin nfail++; $display("FAIL clear_read[%0d] got %h exp 0", addrs[j], d); end
         nchk++; if (lat != 1) begin nfail++; $display("FAIL clear_read_lat[%0d] got %0d exp 1", addrs[j], lat); end
      end
   endtask

   task automatic test_byte_en();
      logic [W-1:0] d;
      int lat;
      do_write(0, 9'd5, 64'h1122_3344_5566_7788, 8'hFF);
      do_write(0, 9'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
      do_read(0, 9'd5, d, lat);
      nchk++; if (d !== 64'h1122_3344_AAAA_AAAA) begin nfail++; $display("FAIL byte_en got %h exp 11223344aaaaaaaa", d); end
      nchk++; if (lat != 1) begin nfail++; $display("FAIL byte_en_lat got %0d exp 1", lat); end
   endtask

   task automatic test_collision(input int k, input logic [W-1:0] exp_d, input int exp_lat);
      logic [W-1:0] d;
      int lat = -1;
      d = '0;
      wren[k] = 1'b1; wa[k] = 9'd9; di[k] = '1; be[k] = 8'h01;
      rden[k] = 1'b1; ra[k] = 9'd9;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) begin wren[k] = 1'b0; be[k] = '0; rden[k] = 1'b0; end
         if (dv[k] === 1'b1 && lat < 0) begin lat = i; d = dout[k]; end
      end
      nchk++; if (d !== exp_d) begin nfail++; $display("FAIL collision[%0d] got %h exp %h", k, d, exp_d); end
      nchk++; if (lat != exp_lat) begin nfail++; $display("FAIL collision_lat[%0d] got %0d exp %0d", k, lat, exp_lat); end
      do_read(k, 9'd9, d, lat);
      nchk++; if (d !== 64'hFF) begin nfail++; $display("FAIL collision_after[%0d] got %h exp ff", k, d); end
   endtask

   task automatic test_latency_throughput();
      bit exp_v;
      int obs;
      for (int a = 0; a < 8; a++) do_write(1, AW'(a), wordv(a), 8'hFF);
      for (int j = 0; j <= 13; j++) begin
         if (j < 8) begin rden[1] = 1'b1; ra[1] = AW'(j); end
         else rden[1] = 1'b0;
         @(negedge clk);
         obs   = j + 1;
         exp_v = (obs >= 3 && obs <= 10);
         nchk++; if (dv[1] !== exp_v) begin nfail++; $display("FAIL b2b_valid cyc %0d got %b exp %b", obs, dv[1], exp_v); end
         if (exp_v) begin
            nchk++; if (dout[1] !== wordv(obs - 3)) begin nfail++; $display("FAIL b2b_data cyc %0d got %h exp %h", obs, dout[1], wordv(obs - 3)); end
         end
      end
      nchk++; if (dout[1] !== wordv(7)) begin nfail++; $display("FAIL b2b_hold got %h exp %h", dout[1], wordv(7)); end
   endtask

   task automatic test_reset_midflight();
      bit saw = 1'b0;
      logic [W-1:0] d;
      int lat;
      do_write(2, 9'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      rden[2] = 1'b1; ra[2] = 9'd3;
      @(negedge clk); if (dv[2] === 1'b1) saw = 1'b1;
      @(negedge clk); if (dv[2] === 1'b1) saw = 1'b1;
      rden[2] = 1'b0; rst_n[2] = 1'b0;
      @(negedge clk); if (dv[2] === 1'b1) saw = 1'b1;
      nchk++; if (dout[2] !== '0) begin nfail++; $display("FAIL midflight_dout got %h exp 0", dout[2]); end
      nchk++; if (id[2] !== 1'b0) begin nfail++; $display("FAIL midflight_init_done got %b exp 0", id[2]); end
      @(negedge clk); if (dv[2] === 1'b1) saw = 1'b1;
      rst_n[2] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (dv[2] === 1'b1) saw = 1'b1;
         if (i == 1) begin
            nchk++; if (id[2] !== 1'b1) begin nfail++; $display("FAIL midflight_rearm got %b exp 1", id[2]); end
         end
      end
      nchk++; if (saw) begin nfail++; $display("FAIL midflight_valid got 1 exp 0"); end
      nchk++; if (dout[2] !== '0) begin nfail++; $display("FAIL midflight_dout_after got %h exp 0", dout[2]); end
      do_read(2, 9'd3, d, lat);
      nchk++; if (d !== 64'hDEAD_BEEF_0123_4567) begin nfail++; $display("FAIL persist got %h exp deadbeef01234567", d); end
      nchk++; if (lat != 4) begin nfail++; $display("FAIL persist_lat got %0d exp 4", lat); end
   endtask

   task automatic test_range_noop();
      logic [W-1:0] d;
      int lat;
      do_write(2, 9'd144, 64'h0123_4567_89AB_CDEF, 8'hFF);
      do_write(2, 9'd400, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      do_read(2, 9'd400, d, lat);
      nchk++; if (d !== '0) begin nfail++; $display("FAIL oor_read got %h exp 0", d); end
      nchk++; if (lat != 4) begin nfail++; $display("FAIL oor_valid_lat got %0d exp 4", lat); end
      do_read(2, 9'd144, d, lat);
      nchk++; if (d !== 64'h0123_4567_89AB_CDEF) begin nfail++; $display("FAIL oor_alias got %h exp 0123456789abcdef", d); end
      do_write(2, 9'd20, 64'h5555_5555_5555_5555, 8'hFF);
      do_write(2, 9'd20, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00);
      do_read(2, 9'd20, d, lat);
      nchk++; if (d !== 64'h5555_5555_5555_5555) begin nfail++; $display("FAIL noop_write got %h exp 5555555555555555", d); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clear_sweep();
      test_byte_en();
      test_collision(0, 64'h0, 1);
      test_latency_throughput();
      test_collision(1, 64'hFF, 3);
      test_reset_midflight();
      test_range_noop();
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
